// File: rtl/uart_tx_feeder.sv
// Purpose: byte FIFO that feeds a UART transmitter one character at a time, pacing start_trig.
// Latency: a write into an empty, idle block raises tx_start in the cycle after the next edge.
// Backpressure: host watches full; writes while full are dropped and flagged on overflow.
module uart_tx_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int GUARD_CYCLES = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_start,
    input  logic                  tx_done,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // Guard counter is sized to hold GUARD_CYCLES-1 for any legal GUARD_CYCLES (>= 2).
    localparam int GW    = $clog2(GUARD_CYCLES + 1);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ZERO_CNT   = '0;
    localparam logic [GW-1:0]       GUARD_LAST = GW'(GUARD_CYCLES - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] GUARD     = 2'd3;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic [1:0]            state;
    logic [GW-1:0]         guard_cnt;
    logic                  tx_done_d;
    logic                  wr_acc;
    logic                  pop;
    logic                  done_rise;

    // Write acceptance uses the registered full flag; only the FSM pops, and only from IDLE.
    always_comb begin
        wr_acc    = wr_en & ~full;
        pop       = (state == IDLE) & ~empty;
        done_rise = tx_done & ~tx_done_d;
    end

    // Occupancy after this edge; a simultaneous write and pop leaves it unchanged.
    always_comb begin
        count_next = count;
        case ({wr_acc, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage is not reset: clearing the pointers and count is enough to flush it.
    // A pop reads the pre-edge slot contents, so a write landing in the same slot is kept for later.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Circular pointers wrap naturally at DEPTH-1 -> 0 through their ADDR_WIDTH-bit width.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Registered occupancy and flags, decoded from the next count so they agree with count.
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            count    <= count_next;
            full     <= (count_next == DEPTH_CNT);
            empty    <= (count_next == ZERO_CNT);
            overflow <= wr_en & full;
        end
    end

    // tx_done is a level that may stay high into the next frame; keep last value to find its rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_done_d <= 1'b0;
        end else begin
            tx_done_d <= tx_done;
        end
    end

    // Issue sequencer: one character per frame, with a guard gap so the transmitter is idle at start.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            guard_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    tx_start <= 1'b0;
                    state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // No timeout: the transmitter always finishes a frame it has started.
                    if (done_rise) begin
                        guard_cnt <= '0;
                        state     <= GUARD;
                    end
                end
                GUARD: begin
                    // Covers the transmitter's return to idle after it flags completion.
                    guard_cnt <= guard_cnt + 1'b1;
                    if (guard_cnt == GUARD_LAST) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Busy covers the whole frame, from issue until the guard interval ends.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Purpose: scoreboard bench for uart_tx_feeder with a simple transmitter responder.
// Latency: expectations pushed at write time, popped whenever tx_start is seen.
// Backpressure: tx_done driven either by the responder or directly by the stimulus.
module tb_uart_tx_feeder;

    localparam int GUARD_CYCLES = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic       busy;

    logic       auto_tx;
    logic       auto_done;
    logic       man_done;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_starts = 0;
    int         cyc = 0;
    int         rise_cyc = 0;
    bit         have_rise = 1'b0;
    logic       prev_done = 1'b0;
    logic [7:0] sb [$];
    logic [7:0] mon_exp;
    int         s0;

    assign tx_done = auto_done | man_done;

    uart_tx_feeder #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (4),
        .GUARD_CYCLES(GUARD_CYCLES)
    ) dut (
        .clock   (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .tx_done (tx_done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Edge bookkeeping: count edges and note the edge at which the DUT sees tx_done rise.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (tx_done === 1'b1 && prev_done === 1'b0) begin
            rise_cyc  = cyc;
            have_rise = 1'b1;
        end
        prev_done = tx_done;
    end

    // Monitor: every tx_start must match the oldest expected byte and respect the guard gap.
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            n_starts++;
            check("start_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                check("tx_data_order", tx_data, mon_exp);
            end
            if (have_rise) begin
                check("guard_gap_ok", ((cyc - rise_cyc) >= GUARD_CYCLES + 1), 1);
                have_rise = 1'b0;
            end
        end
    end

    // Transmitter responder: raises done a few clocks after each start, holds it 3 clocks.
    initial begin
        auto_done = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_tx && tx_start === 1'b1) begin
                repeat (6) @(negedge clk);
                auto_done = 1'b1;
                repeat (3) @(negedge clk);
                auto_done = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr1(input logic [7:0] d, input bit push);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        if (push) sb.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic burst(input logic [7:0] base, input int n, input bit push);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d       = base + 8'(i);
            wr_en   = 1'b1;
            wr_data = d;
            if (push) sb.push_back(d);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic kick_auto();
        auto_tx = 1'b1;
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (empty === 1'b1 && busy === 1'b0 && sb.size() == 0) break;
        end
        check(name, (empty === 1'b1 && busy === 1'b0 && sb.size() == 0), 1);
    endtask

    initial begin
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        auto_tx  = 1'b0;
        man_done = 1'b0;
        tick(3);
        check("rst_empty",    empty,    1);
        check("rst_full",     full,     0);
        check("rst_count",    count,    0);
        check("rst_overflow", overflow, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data",  tx_data,  0);
        check("rst_busy",     busy,     0);
        reset = 1'b0;

        // Single write: start appears two clocks after the write strobe.
        auto_tx = 1'b1;
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        sb.push_back(8'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        check("t1_empty_after_wr", empty, 0);
        check("t1_count_after_wr", count, 1);
        check("t1_no_start_yet",   tx_start, 0);
        @(negedge clk);
        check("t1_start",      tx_start, 1);
        check("t1_tx_data",    tx_data,  8'hA5);
        check("t1_empty_pop",  empty,    1);
        check("t1_busy",       busy,     1);
        @(negedge clk);
        check("t1_start_1clk", tx_start, 0);
        check("t1_busy_held",  busy,     1);
        wait_idle("t1_drain");
        check("t1_tx_data_held", tx_data, 8'hA5);

        // Burst of four with the responder draining.
        s0 = n_starts;
        burst(8'h01, 4, 1'b1);
        wait_idle("t2_drain");
        check("t2_start_count", n_starts - s0, 4);

        // Fill while the sequencer waits on a frame that never completes.
        auto_tx = 1'b0;
        wr1(8'h10, 1'b1);
        tick(4);
        check("t3_busy_waiting", busy, 1);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 16) begin
                check("t3_full_16",  full,     1);
                check("t3_count_16", count,    16);
                check("t3_no_ovf",   overflow, 0);
            end
            wr_en   = 1'b1;
            wr_data = (i < 16) ? (8'h20 + 8'(i)) : 8'h3F;
            if (i < 16) sb.push_back(8'h20 + 8'(i));
        end
        @(negedge clk);
        wr_en = 1'b0;
        check("t3_overflow_pulse", overflow, 1);
        check("t3_count_kept",     count,    16);
        check("t3_full_kept",      full,     1);
        @(negedge clk);
        check("t3_overflow_1clk",  overflow, 0);

        // tx_done held high: only a genuine rise releases the next character.
        s0 = n_starts;
        @(negedge clk);
        man_done = 1'b1;
        tick(30);
        check("t4_one_issue_on_rise", n_starts - s0, 1);
        check("t4_count_15",          count, 15);
        check("t4_stuck_busy",        busy,  1);
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        man_done = 1'b1;
        tick(10);
        check("t4_issue_after_new_rise", n_starts - s0, 2);
        check("t4_count_14",             count, 14);
        @(negedge clk);
        man_done = 1'b0;
        kick_auto();
        wait_idle("t4_drain");

        // Pointer wrap: fill, drain ten, refill ten, then check order over the whole run.
        auto_tx = 1'b0;
        wr1(8'h40, 1'b1);
        tick(4);
        burst(8'h50, 16, 1'b1);
        check("t5_count_full", count, 16);
        check("t5_full",       full,  1);
        repeat (10) pulse_done();
        check("t5_count_after_drain", count, 6);
        burst(8'h60, 10, 1'b1);
        check("t5_count_refill", count, 16);
        check("t5_full_refill",  full,  1);
        kick_auto();
        wait_idle("t5_drain");

        // Reset mid-frame with entries queued: everything is discarded.
        auto_tx = 1'b0;
        wr1(8'h70, 1'b1);
        tick(4);
        burst(8'h80, 5, 1'b0);
        check("t6_count_5",      count, 5);
        check("t6_busy_waiting", busy,  1);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        have_rise = 1'b0;
        @(negedge clk);
        check("t6_empty",    empty,    1);
        check("t6_count",    count,    0);
        check("t6_busy",     busy,     0);
        check("t6_tx_start", tx_start, 0);
        check("t6_full",     full,     0);
        reset = 1'b0;
        s0 = n_starts;
        tick(30);
        check("t6_no_start_after_reset", n_starts - s0, 0);
        check("t6_still_empty",          empty, 1);

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
